// File: rtl/addsub_nibble_sched.sv
// Round-robin shared nibble-serial WIDTH-bit add/sub engine for N_REQ requesters.
// Optional saturation of rsp_s on signed overflow: define ADDSUB_SAT_EN.
//
// state  | meaning
// S_IDLE | waiting for a request; grant and operand capture happen here
// S_BUSY | one 4-bit slice per cycle, LSB nibble first, carry kept in r_carry
// S_DONE | response presented, held until rsp_ready
module addsub_nibble_sched #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0]       req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_s,
  output logic                   rsp_cout,
  output logic                   rsp_ovf
);

  localparam int N_NIB = WIDTH / 4;
  localparam int CNT_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_op_sub;
  logic [3:0]       w_lo;
  logic [4:0]       w_slice;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_s_final;

  // Scan upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_gnt_vld && req_valid[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ID_W'(j);
      end
    end
  end

  assign req_ready = (r_state == S_IDLE && w_gnt_vld) ? (N_REQ'(1) << w_gnt) : '0;
  assign w_ptr_nxt = (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
  assign w_op_a    = req_a[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_op_b    = req_b[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_op_sub  = req_sub[w_gnt];

  // The 3-bit partial sum exposes the carry into the slice MSB for overflow.
  assign w_lo    = {1'b0, r_a[2:0]} + {1'b0, r_b[2:0]} + {3'b0, r_carry};
  assign w_slice = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
  assign w_ovf   = w_lo[3] ^ w_slice[4];
  assign w_res   = WIDTH'({w_slice[3:0], r_acc} >> 4);

`ifdef ADDSUB_SAT_EN
  // Wrapped MSB set means the true result was positive, and vice versa.
  assign w_s_final = w_ovf ? {~w_res[WIDTH-1], {(WIDTH-1){w_res[WIDTH-1]}}} : w_res;
`else
  assign w_s_final = w_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_a     <= w_op_a;
            r_b     <= w_op_b ^ {WIDTH{w_op_sub}};
            r_carry <= w_op_sub;
            r_id    <= w_gnt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= CNT_W'(N_NIB - 1);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_slice[4];
          r_acc   <= w_res;
          if (r_cnt == '0) begin
            rsp_s     <= w_s_final;
            rsp_cout  <= w_slice[4];
            rsp_ovf   <= w_ovf;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
